// File: rtl/pa_spsram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pa_spsram_pkg : shared types and constants for the single-port SRAM        |
// |                 controller (controller FSM states, response FIFO sizing).  |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
package pa_spsram_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int RSP_DEPTH = 2;
  localparam int CREDIT_W  = $clog2(RSP_DEPTH + 1);

endpackage
`default_nettype wire

// File: rtl/pa_f_spsram_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pa_f_spsram_param : generic single-port SRAM macro, active-low controls,   |
// |                     1-cycle read latency, bitwise write enable.            |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
module pa_f_spsram_param #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 36
) (
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  CEN,
  input  logic                  CLK,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic                  GWEN,
  input  logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] Q
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_q;

  // WEN low selects D for that bit; Q only updates on a read access
  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) begin
        r_mem[A] <= (r_mem[A] & WEN) | (D & ~WEN);
      end else begin
        r_q <= r_mem[A];
      end
    end
  end

  assign Q = r_q;

endmodule
`default_nettype wire

// File: rtl/pa_spsram_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pa_spsram_ctrl : valid/ready wrapper around pa_f_spsram_param with masked  |
// |                  writes, 2-entry read-response buffer and optional array   |
// |                  init walk (enabled by PA_SPSRAM_CTRL_INIT_EN).            |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module pa_spsram_ctrl
  import pa_spsram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 36,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done
);

  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_init_wr;
  logic                  w_ready_base;
  logic [ADDR_WIDTH-1:0] w_init_addr;
  logic [CREDIT_W-1:0]   w_credits_used;

  logic                  w_cen;
  logic                  w_gwen;
  logic [DATA_WIDTH-1:0] w_wen;
  logic [ADDR_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_d;
  logic [DATA_WIDTH-1:0] w_q;

  logic                  r_rd_inflight;
  logic [CREDIT_W-1:0]   r_cnt;
  logic                  r_wptr;
  logic                  r_rptr;
  logic [DATA_WIDTH-1:0] r_buf [RSP_DEPTH];

`ifdef PA_SPSRAM_CTRL_INIT_EN
  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_init_addr;
  logic                  r_init_done;

  // One INIT_VALUE write per cycle; the counter wrapping marks the last address
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state     <= ST_INIT;
      r_init_addr <= '0;
      r_init_done <= 1'b0;
    end else if (r_state == ST_INIT) begin
      r_init_addr <= r_init_addr + ADDR_WIDTH'(1);
      if (r_init_addr == '1) begin
        r_state     <= ST_RUN;
        r_init_done <= 1'b1;
      end
    end
  end

  assign w_init_wr    = (r_state == ST_INIT);
  assign w_init_addr  = r_init_addr;
  assign w_ready_base = r_init_done;
  assign init_done    = r_init_done;
`else
  logic r_run;

  // Holds off requests while reset is asserted even though the array needs no init
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  assign w_init_wr    = 1'b0;
  assign w_init_addr  = '0;
  assign w_ready_base = r_run;
  assign init_done    = 1'b1;
`endif

  // A read holds a credit from acceptance until its data leaves the buffer
  assign w_credits_used = {{(CREDIT_W-1){1'b0}}, r_rd_inflight} + r_cnt;
  assign req_rdy  = w_ready_base & (req_wr | (w_credits_used < CREDIT_W'(RSP_DEPTH)));
  assign w_accept = req_vld & req_rdy;
  assign w_push   = r_rd_inflight;
  assign w_pop    = rsp_vld & rsp_rdy;

  assign w_cen  = ~(w_accept | w_init_wr);
  assign w_gwen = ~(w_init_wr | req_wr);
  assign w_wen  = w_init_wr ? '0 : ~req_wmask;
  assign w_a    = w_init_wr ? w_init_addr : req_addr;
  assign w_d    = w_init_wr ? INIT_VALUE : req_wdata;

  pa_f_spsram_param #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sram (
    .A    (w_a),
    .CEN  (w_cen),
    .CLK  (forever_cpuclk),
    .D    (w_d),
    .GWEN (w_gwen),
    .WEN  (w_wen),
    .Q    (w_q)
  );

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_rd_inflight <= 1'b0;
      r_cnt         <= '0;
      r_wptr        <= 1'b0;
      r_rptr        <= 1'b0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_rd_inflight <= w_accept & ~req_wr;
      if (w_push) begin
        r_buf[r_wptr] <= w_q;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CREDIT_W'(1);
        2'b01:   r_cnt <= r_cnt - CREDIT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign rsp_vld   = (r_cnt != '0);
  assign rsp_rdata = r_buf[r_rptr];

endmodule
`default_nettype wire

// File: tb/tb_pa_spsram_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pa_spsram_ctrl : directed self-checking bench for pa_spsram_ctrl        |
// |                     (init walk paths active with PA_SPSRAM_CTRL_INIT_EN).  |
// | Revision          : 1.0                                                    |
// +----------------------------------------------------------------------------+
module tb_pa_spsram_ctrl;

  localparam int          AW = 4;
  localparam int          DW = 36;
  localparam logic [35:0] IV = 36'h5A5A5A5A5;
  localparam logic [35:0] M1 = 36'hF_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          cpurst_b;
  logic          req_vld;
  logic          req_rdy;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [DW-1:0] req_wmask;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] wmask;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vt [12];

  always #5 clk = ~clk;

  pa_spsram_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .INIT_VALUE (IV)
  ) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (cpurst_b),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_wmask      (req_wmask),
    .rsp_vld        (rsp_vld),
    .rsp_rdy        (rsp_rdy),
    .rsp_rdata      (rsp_rdata),
    .init_done      (init_done)
  );

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; returns at a negedge with the request dropped
  task automatic do_op(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] m, input logic [DW-1:0] exp, input string nm);
    int k;
    req_vld = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; req_wmask = m;
    #1;
    k = 0;
    while (!req_rdy && k < 20) begin
      step(); #1; k++;
    end
    chk({nm, "_rdy"}, {35'd0, req_rdy}, 36'd1);
    step();
    req_vld = 1'b0;
    if (!wr) begin
      chk({nm, "_early"}, {35'd0, rsp_vld}, 36'd0);
      step();
      chk({nm, "_vld"}, {35'd0, rsp_vld}, 36'd1);
      chk({nm, "_data"}, rsp_rdata, exp);
      step();
    end
  endtask

  // Returns the number of cycles from the current negedge until init_done is seen
  task automatic wait_init(output int cyc, output logic rdy_seen);
    cyc = 0;
    rdy_seen = req_rdy;
    while (!init_done && cyc < 40) begin
      step();
      cyc++;
      if (!init_done && req_rdy) rdy_seen = 1'b1;
    end
  endtask

  initial begin
    int   cyc;
    int   vld_seen;
    logic rdy_seen;

    vt[0]  = '{1'b1, 4'd3,  M1,             M1,             36'h0};
    vt[1]  = '{1'b1, 4'd3,  36'h0,          36'h0_0000_00FF, 36'h0};
    vt[2]  = '{1'b0, 4'd3,  36'h0,          36'h0,          36'hF_FFFF_FF00};
    vt[3]  = '{1'b1, 4'd5,  36'h1_2345_6789, 36'hF_0000_FFFF, 36'h0};
    vt[4]  = '{1'b0, 4'd5,  36'h0,          36'h0,          36'h1_A5A5_6789};
    vt[5]  = '{1'b1, 4'd5,  M1,             36'h0,          36'h0};
    vt[6]  = '{1'b0, 4'd5,  36'h0,          36'h0,          36'h1_A5A5_6789};
    vt[7]  = '{1'b1, 4'd0,  36'h0,          M1,             36'h0};
    vt[8]  = '{1'b0, 4'd0,  36'h0,          36'h0,          36'h0};
    vt[9]  = '{1'b1, 4'd15, 36'hA_BCDE_F012, M1,             36'h0};
    vt[10] = '{1'b0, 4'd15, 36'h0,          36'h0,          36'hA_BCDE_F012};
    vt[11] = '{1'b0, 4'd14, 36'h0,          36'h0,          IV};

    cpurst_b = 1'b0; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; rsp_rdy = 1'b1;
    step(); step(); #1;
    chk("rst_req_rdy", {35'd0, req_rdy}, 36'd0);
    chk("rst_rsp_vld", {35'd0, rsp_vld}, 36'd0);
    chk("rst_rsp_rdata", rsp_rdata, 36'd0);
`ifdef PA_SPSRAM_CTRL_INIT_EN
    chk("rst_init_done", {35'd0, init_done}, 36'd0);
    @(negedge clk);
    cpurst_b = 1'b1;
    wait_init(cyc, rdy_seen);
    chk("init_cycles", 36'(cyc), 36'd16);
    chk("init_rdy_low", {35'd0, rdy_seen}, 36'd0);
    for (int a = 0; a < 16; a++) do_op(1'b0, 4'(a), '0, '0, IV, $sformatf("init_rd%0d", a));
`else
    chk("rst_init_done", {35'd0, init_done}, 36'd1);
    @(negedge clk);
    cpurst_b = 1'b1;
    step(); #1;
    chk("run_req_rdy", {35'd0, req_rdy}, 36'd1);
    for (int a = 0; a < 16; a++) do_op(1'b1, 4'(a), IV, M1, '0, "prefill");
    do_op(1'b0, 4'd9, '0, '0, IV, "prefill_rd9");
`endif

    for (int i = 0; i < 12; i++)
      do_op(vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].wmask, vt[i].exp, $sformatf("vec%0d", i));

    // Backpressure: two reads fill the credits, a write still passes
    do_op(1'b1, 4'd1, 36'h1_1111_1111, M1, '0, "bp_w1");
    do_op(1'b1, 4'd2, 36'h2_2222_2222, M1, '0, "bp_w2");
    do_op(1'b1, 4'd3, 36'h3_3333_3333, M1, '0, "bp_w3");
    rsp_rdy = 1'b0;
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 4'd1; #1;
    chk("bp_rd1_rdy", {35'd0, req_rdy}, 36'd1);
    step(); req_addr = 4'd2; #1;
    chk("bp_rd2_rdy", {35'd0, req_rdy}, 36'd1);
    step(); req_addr = 4'd3; #1;
    chk("bp_rd3_stall", {35'd0, req_rdy}, 36'd0);
    step();
    chk("bp_full_vld", {35'd0, rsp_vld}, 36'd1);
    chk("bp_head1", rsp_rdata, 36'h1_1111_1111);
    req_wr = 1'b1; req_addr = 4'd7; req_wdata = 36'h7_7777_7777; req_wmask = M1; #1;
    chk("bp_wr_pass", {35'd0, req_rdy}, 36'd1);
    step();
    req_wr = 1'b0; req_addr = 4'd3; #1;
    chk("bp_rd3_still", {35'd0, req_rdy}, 36'd0);
    chk("bp_hold1", rsp_rdata, 36'h1_1111_1111);
    rsp_rdy = 1'b1;
    step(); #1;
    chk("bp_credit_free", {35'd0, req_rdy}, 36'd1);
    chk("bp_head2", rsp_rdata, 36'h2_2222_2222);
    step();
    req_vld = 1'b0;
    chk("bp_empty", {35'd0, rsp_vld}, 36'd0);
    step();
    chk("bp_vld3", {35'd0, rsp_vld}, 36'd1);
    chk("bp_head3", rsp_rdata, 36'h3_3333_3333);
    step();
    chk("bp_drained", {35'd0, rsp_vld}, 36'd0);
    do_op(1'b0, 4'd7, '0, '0, 36'h7_7777_7777, "bp_rd7");

`ifdef PA_SPSRAM_CTRL_INIT_EN
    // Reset in the middle of the init walk restarts it from address 0
    cpurst_b = 1'b0;
    step();
    cpurst_b = 1'b1;
    for (int i = 0; i < 9; i++) step();
    chk("mid_init_busy", {35'd0, init_done}, 36'd0);
    cpurst_b = 1'b0;
    step(); step();
    cpurst_b = 1'b1;
    wait_init(cyc, rdy_seen);
    chk("reinit_cycles", 36'(cyc), 36'd16);
    chk("reinit_rdy_low", {35'd0, rdy_seen}, 36'd0);
`endif

    // Reset with a full response buffer discards everything
    rsp_rdy = 1'b0;
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 4'd1;
    step(); req_addr = 4'd2;
    step(); req_vld = 1'b0;
    step();
    chk("rst5_full", {35'd0, rsp_vld}, 36'd1);
    cpurst_b = 1'b0; #1;
    chk("rst5_vld_drop", {35'd0, rsp_vld}, 36'd0);
    chk("rst5_rdata_clr", rsp_rdata, 36'd0);
    step(); step();
    cpurst_b = 1'b1;
    wait_init(cyc, rdy_seen);
    rsp_rdy = 1'b1;
    vld_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (rsp_vld) vld_seen++;
    end
    chk("rst5_no_stale", 36'(vld_seen), 36'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
